// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage RV32I core, with load-use bubble
// insertion, flush on taken branch/jump, downstream stall and a bubble counter.
module id_ex_stage #(
   parameter int          XLEN   = 32,
   parameter logic [15:0] BUBBLE = 16'h8200,
   parameter int          CNT_W  = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             valid_i,
   input  logic             WB_i,
   input  logic [5:0]       MEM_i,
   input  logic [8:0]       EX_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic [XLEN-1:0]  data1_i,
   input  logic [XLEN-1:0]  data2_i,
   input  logic [XLEN-1:0]  imm_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   input  logic [4:0]       rd_i,
   output logic             WB_o,
   output logic [5:0]       MEM_o,
   output logic [8:0]       EX_o,
   output logic [XLEN-1:0]  pc_o,
   output logic [XLEN-1:0]  data1_o,
   output logic [XLEN-1:0]  data2_o,
   output logic [XLEN-1:0]  imm_o,
   output logic [4:0]       rs1_o,
   output logic [4:0]       rs2_o,
   output logic [4:0]       rd_o,
   output logic             valid_o,
   output logic             hazard_stall_o,
   output logic [CNT_W-1:0] bubble_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Control word layout: {WB[15], MEM[14:9], EX[8:0]}.
   logic [15:0]      r_ctrl;
   logic             r_valid;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  r_data1;
   logic [XLEN-1:0]  r_data2;
   logic [XLEN-1:0]  r_imm;
   logic [4:0]       r_rs1;
   logic [4:0]       r_rs2;
   logic [4:0]       r_rd;
   logic [CNT_W-1:0] r_cnt;

   logic             w_lu;

   // A load in EX (mux select 1 = memory data) whose rd feeds either source
   // of the instruction in ID. x0 is never written, so rd==0 cannot hazard.
   assign w_lu = r_valid & ~r_ctrl[15] & (r_ctrl[14:13] == 2'd1) &
                 (r_rd != 5'd0) & valid_i &
                 ((r_rd == rs1_i) | (r_rd == rs2_i));

   assign hazard_stall_o = w_lu & ~flush_i & ~stall_i;

   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset_i) begin
         r_ctrl  <= BUBBLE;
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_data1 <= '0;
         r_data2 <= '0;
         r_imm   <= '0;
         r_rs1   <= '0;
         r_rs2   <= '0;
         r_rd    <= '0;
         r_cnt   <= '0;
      end else if (flush_i) begin
         r_ctrl  <= BUBBLE;
         r_valid <= 1'b0;
      end else if (stall_i) begin
         r_ctrl  <= r_ctrl;
         r_valid <= r_valid;
      end else if (w_lu) begin
         // Datapath fields are held; only control is squashed.
         r_ctrl  <= BUBBLE;
         r_valid <= 1'b0;
         if (r_cnt != CNT_MAX)
            r_cnt <= r_cnt + CNT_ONE;
      end else begin
         r_ctrl  <= valid_i ? {WB_i, MEM_i, EX_i} : BUBBLE;
         r_valid <= valid_i;
         r_pc    <= pc_i;
         r_data1 <= data1_i;
         r_data2 <= data2_i;
         r_imm   <= imm_i;
         r_rs1   <= rs1_i;
         r_rs2   <= rs2_i;
         r_rd    <= rd_i;
      end
   end

   assign WB_o         = r_ctrl[15];
   assign MEM_o        = r_ctrl[14:9];
   assign EX_o         = r_ctrl[8:0];
   assign valid_o      = r_valid;
   assign pc_o         = r_pc;
   assign data1_o      = r_data1;
   assign data2_o      = r_data2;
   assign imm_o        = r_imm;
   assign rs1_o        = r_rs1;
   assign rs2_o        = r_rs2;
   assign rd_o         = r_rd;
   assign bubble_cnt_o = r_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a table of directed vectors plus
// hand-written reset, stall-hold, saturation and reset-mid-stall sequences.
module tb_id_ex_stage;

   localparam logic [15:0] C_ADD = 16'h0001;
   localparam logic [15:0] C_LW  = 16'h2810;
   localparam logic [15:0] C_BUB = 16'h8200;

   logic        clk_i = 1'b0;
   logic        reset_i, stall_i, flush_i, valid_i, WB_i;
   logic [5:0]  MEM_i;
   logic [8:0]  EX_i;
   logic [31:0] pc_i, data1_i, data2_i, imm_i;
   logic [4:0]  rs1_i, rs2_i, rd_i;
   logic        WB_o;
   logic [5:0]  MEM_o;
   logic [8:0]  EX_o;
   logic [31:0] pc_o, data1_o, data2_o, imm_o;
   logic [4:0]  rs1_o, rs2_o, rd_o;
   logic        valid_o, hazard_stall_o;
   logic [1:0]  bubble_cnt_o;

   int checks = 0;
   int errors = 0;

   id_ex_stage #(.XLEN(32), .BUBBLE(16'h8200), .CNT_W(2)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .WB_i(WB_i), .MEM_i(MEM_i), .EX_i(EX_i),
      .pc_i(pc_i), .data1_i(data1_i), .data2_i(data2_i), .imm_i(imm_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
      .WB_o(WB_o), .MEM_o(MEM_o), .EX_o(EX_o),
      .pc_o(pc_o), .data1_o(data1_o), .data2_o(data2_o), .imm_o(imm_o),
      .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
      .valid_o(valid_o), .hazard_stall_o(hazard_stall_o),
      .bubble_cnt_o(bubble_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        stall, flush, valid;
      logic [15:0] ctrl;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic        e_hz;
      logic [15:0] e_ctrl;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [4:0]  e_rd;
      logic [1:0]  e_cnt;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic fl, input logic va,
                               input logic [15:0] ct, input logic [31:0] pc,
                               input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                               input logic hz, input logic [15:0] ect, input logic eva,
                               input logic [31:0] epc, input logic [4:0] erd, input logic [1:0] ecnt);
      vec_t v;
      v.stall = st; v.flush = fl; v.valid = va; v.ctrl = ct; v.pc = pc;
      v.rs1 = r1; v.rs2 = r2; v.rd = rd; v.e_hz = hz; v.e_ctrl = ect;
      v.e_valid = eva; v.e_pc = epc; v.e_rd = erd; v.e_cnt = ecnt;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      stall_i = v.stall; flush_i = v.flush; valid_i = v.valid;
      WB_i = v.ctrl[15]; MEM_i = v.ctrl[14:9]; EX_i = v.ctrl[8:0];
      pc_i = v.pc; data1_i = v.pc + 32'h1000; data2_i = v.pc + 32'h2000;
      imm_i = v.pc + 32'h3000;
      rs1_i = v.rs1; rs2_i = v.rs2; rd_i = v.rd;
   endtask

   function automatic logic [15:0] ctrl_o();
      return {WB_o, MEM_o, EX_o};
   endfunction

   task automatic do_reset();
      @(negedge clk_i);
      reset_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         stall_i = 1'($urandom); flush_i = 1'($urandom); valid_i = 1'($urandom);
         WB_i = 1'($urandom); MEM_i = 6'($urandom); EX_i = 9'($urandom);
         pc_i = $urandom; data1_i = $urandom; data2_i = $urandom; imm_i = $urandom;
         rs1_i = 5'($urandom); rs2_i = 5'($urandom); rd_i = 5'($urandom);
         @(posedge clk_i); #1;
      end
      @(negedge clk_i);
      reset_i = 1'b0;
      drive(mk(0,0,0, C_BUB, 0, 0,0,0, 0, C_BUB, 0, 0, 0, 0));
      #1;
   endtask

   task automatic step(input vec_t v, input string tag);
      @(negedge clk_i);
      drive(v);
      #1;
      check({tag, ".hazard"}, 64'(hazard_stall_o), 64'(v.e_hz));
      @(posedge clk_i); #1;
      check({tag, ".ctrl"},  64'(ctrl_o()),      64'(v.e_ctrl));
      check({tag, ".valid"}, 64'(valid_o),       64'(v.e_valid));
      check({tag, ".pc"},    64'(pc_o),          64'(v.e_pc));
      check({tag, ".rd"},    64'(rd_o),          64'(v.e_rd));
      check({tag, ".cnt"},   64'(bubble_cnt_o),  64'(v.e_cnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_i = 1'b0;
      drive(mk(0,0,0, C_BUB, 0, 0,0,0, 0, C_BUB, 0, 0, 0, 0));

      // stall, flush, valid, ctrl, pc, rs1, rs2, rd | hz, ctrl, valid, pc, rd, cnt
      vecs[0]  = mk(0,0,1, C_ADD, 32'h100, 1,2,3,  0, C_ADD, 1, 32'h100, 3, 0);
      vecs[1]  = mk(0,0,1, C_LW,  32'h104, 2,0,5,  0, C_LW,  1, 32'h104, 5, 0);
      vecs[2]  = mk(0,0,1, C_ADD, 32'h108, 5,6,7,  1, C_BUB, 0, 32'h104, 5, 1);
      vecs[3]  = mk(0,0,1, C_ADD, 32'h108, 5,6,7,  0, C_ADD, 1, 32'h108, 7, 1);
      vecs[4]  = mk(0,0,1, C_LW,  32'h10C, 1,0,0,  0, C_LW,  1, 32'h10C, 0, 1);
      vecs[5]  = mk(0,0,1, C_ADD, 32'h110, 0,0,8,  0, C_ADD, 1, 32'h110, 8, 1);
      vecs[6]  = mk(0,0,1, C_LW,  32'h114, 1,0,5,  0, C_LW,  1, 32'h114, 5, 1);
      vecs[7]  = mk(0,0,1, C_ADD, 32'h118, 6,7,9,  0, C_ADD, 1, 32'h118, 9, 1);
      vecs[8]  = mk(0,0,1, C_LW,  32'h11C, 1,0,5,  0, C_LW,  1, 32'h11C, 5, 1);
      vecs[9]  = mk(1,1,1, C_ADD, 32'h120, 6,5,9,  0, C_BUB, 0, 32'h11C, 5, 1);
      vecs[10] = mk(0,0,0, C_ADD, 32'h124, 1,2,10, 0, C_BUB, 0, 32'h124, 10, 1);
      vecs[11] = mk(0,0,1, C_LW,  32'h128, 1,0,5,  0, C_LW,  1, 32'h128, 5, 1);
      vecs[12] = mk(0,0,0, C_ADD, 32'h12C, 6,5,11, 0, C_BUB, 0, 32'h12C, 11, 1);
      vecs[13] = mk(0,0,1, C_LW,  32'h130, 1,0,5,  0, C_LW,  1, 32'h130, 5, 1);
      vecs[14] = mk(1,0,1, C_ADD, 32'h134, 5,6,9,  0, C_LW,  1, 32'h130, 5, 1);
      vecs[15] = mk(0,0,1, C_ADD, 32'h134, 5,6,9,  1, C_BUB, 0, 32'h130, 5, 2);
      vecs[16] = mk(0,0,1, C_ADD, 32'h134, 5,6,9,  0, C_ADD, 1, 32'h134, 9, 2);

      // Reset state after two cycles of random inputs.
      do_reset();
      check("reset.ctrl",   64'(ctrl_o()),       64'(C_BUB));
      check("reset.valid",  64'(valid_o),        64'd0);
      check("reset.cnt",    64'(bubble_cnt_o),   64'd0);
      check("reset.hazard", 64'(hazard_stall_o), 64'd0);
      check("reset.data",   {pc_o, data1_o},     64'd0);
      check("reset.data2",  {data2_o, imm_o},    64'd0);
      check("reset.idx",    64'({rs1_o, rs2_o, rd_o}), 64'd0);

      // Plain load: every captured field appears one cycle later.
      @(negedge clk_i);
      drive(mk(0,0,1, C_ADD, 32'h100, 1,2,3, 0, 0, 0, 0, 0, 0));
      @(posedge clk_i); #1;
      check("load.ctrl",  64'(ctrl_o()), 64'(C_ADD));
      check("load.valid", 64'(valid_o),  64'd1);
      check("load.pc",    64'(pc_o),     64'h100);
      check("load.data1", 64'(data1_o),  64'h1100);
      check("load.data2", 64'(data2_o),  64'h2100);
      check("load.imm",   64'(imm_o),    64'h3100);
      check("load.idx",   64'({rs1_o, rs2_o, rd_o}), 64'({5'd1, 5'd2, 5'd3}));

      for (int i = 0; i < 17; i++)
         step(vecs[i], $sformatf("vec%0d", i));

      // Stall hold: outputs stay constant while inputs change.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         drive(mk(1,0,1, C_LW, 32'h200 + 32'(i*4), 5'(i+1), 5'(i+2), 5'(i+20),
                  0, 0, 0, 0, 0, 0));
         @(posedge clk_i); #1;
         check($sformatf("stall%0d.ctrl", i),  64'(ctrl_o()), 64'(C_ADD));
         check($sformatf("stall%0d.pc", i),    64'(pc_o),     64'h134);
         check($sformatf("stall%0d.data1", i), 64'(data1_o),  64'h1134);
         check($sformatf("stall%0d.rd", i),    64'(rd_o),     64'd9);
         check($sformatf("stall%0d.valid", i), 64'(valid_o),  64'd1);
         check($sformatf("stall%0d.cnt", i),   64'(bubble_cnt_o), 64'd2);
      end

      // Saturation of the 2-bit counter over five bubbles.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         drive(mk(0,0,1, C_LW, 32'h300, 1,0,5, 0, 0, 0, 0, 0, 0));
         @(posedge clk_i);
         @(negedge clk_i);
         drive(mk(0,0,1, C_ADD, 32'h304, 5,5,6, 0, 0, 0, 0, 0, 0));
         #1;
         check($sformatf("sat%0d.hazard", i), 64'(hazard_stall_o), 64'd1);
         @(posedge clk_i); #1;
         check($sformatf("sat%0d.cnt", i), 64'(bubble_cnt_o), 64'((i + 1 > 3) ? 3 : i + 1));
         @(posedge clk_i); #1;
         check($sformatf("sat%0d.after", i), 64'(ctrl_o()), 64'(C_ADD));
      end

      // Reset asserted while a load-use stall is pending.
      @(negedge clk_i);
      drive(mk(0,0,1, C_LW, 32'h400, 1,0,5, 0, 0, 0, 0, 0, 0));
      @(posedge clk_i);
      @(negedge clk_i);
      drive(mk(0,0,1, C_ADD, 32'h404, 5,0,6, 0, 0, 0, 0, 0, 0));
      #1;
      check("rststall.pre", 64'(hazard_stall_o), 64'd1);
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      check("rststall.hazard", 64'(hazard_stall_o), 64'd0);
      check("rststall.valid",  64'(valid_o),        64'd0);
      check("rststall.ctrl",   64'(ctrl_o()),       64'(C_BUB));
      check("rststall.cnt",    64'(bubble_cnt_o),   64'd0);
      check("rststall.rd",     64'(rd_o),           64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RV32I core.
- Captures the decode-stage control word ({WB_o, MEM_o[5:0], EX_o[8:0]}), operands, immediate, PC and register indices, and presents them to the execute stage.
- Contains load-use hazard detection: inserts a one-cycle bubble and holds IF/ID and PC.
- Handles flush on taken branch/jump, and downstream stall.

Parameters:
XLEN, 32, datapath width
BUBBLE, 16'h8200, control word for a bubble: WB=1 (no regfile write, active-low), MEM_WEN=1 (no store, active-low), all other bits 0
CNT_W, 16, width of the bubble performance counter

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  synchronous, active-high reset
stall_i  input  1  downstream hold (memory busy); register keeps its contents
flush_i  input  1  taken branch/jump resolved in EX; discard ID contents
valid_i  input  1  ID stage holds a real instruction
WB_i  input  1  decode control, regfile write enable (active-low)
MEM_i  input  6  decode control, [5:4] mux, [3] sign, [2:1] length, [0] wen (active-low)
EX_i  input  9  decode control, [8] B, [7] J, [6:4] muxes, [3:0] ALU op
pc_i  input  XLEN  instruction PC
data1_i  input  XLEN  rs1 value
data2_i  input  XLEN  rs2 value
imm_i  input  XLEN  immediate
rs1_i  input  5  source index 1
rs2_i  input  5  source index 2
rd_i  input  5  destination index
WB_o  output  1  registered WB
MEM_o  output  6  registered MEM
EX_o  output  9  registered EX
pc_o, data1_o, data2_o, imm_o  output  XLEN  registered datapath values
rs1_o, rs2_o, rd_o  output  5  registered indices
valid_o  output  1  EX holds a real instruction
hazard_stall_o  output  1  combinational; hold PC and IF/ID this cycle
bubble_cnt_o  output  CNT_W  count of inserted bubbles, saturating

Behaviour:
- Reset (reset_i=1 at a clock edge):
  - Control word = BUBBLE.
  - valid_o=0; all datapath, index and counter registers = 0.
  - Reset takes priority over every other input.
- Load-use detect (combinational): lu = valid_o & ~WB_o & (MEM_o[5:4]==2'd1) & (rd_o!=0) & valid_i & ((rd_o==rs1_i)|(rd_o==rs2_i)).
  - Both sources are compared regardless of instruction format; a false stall is acceptable.
- hazard_stall_o = lu & ~flush_i & ~stall_i.
- Per-edge update priority (highest first):
  1. reset_i.
  2. flush_i: control = BUBBLE, valid_o=0, counter unchanged. Flush wins over stall_i and lu.
  3. stall_i: all registers hold, counter unchanged.
  4. lu: control = BUBBLE, valid_o=0, bubble_cnt_o += 1. Datapath fields don't-care; implementation holds them.
  5. Otherwise load:
     - valid_i=1: control = {WB_i, MEM_i, EX_i}, all fields captured.
     - valid_i=0: control = BUBBLE, valid_o=0, datapath fields captured.
- Latency: one cycle from ID inputs to outputs.
- A load-use stall lasts exactly one cycle. After the bubble, valid_o=0, so lu deasserts and the held ID instruction loads on the next edge.
- bubble_cnt_o saturates at all-ones; there is no wrap.
- rd_o==0 never triggers lu (x0 is never written).
- Reset asserted mid-stall: next edge clears everything; hazard_stall_o drops as soon as valid_o=0.

Test Plan:
- Reset: hold reset_i for 2 cycles with random inputs -> WB_o=1, MEM_o=6'b000001, EX_o=0, valid_o=0, bubble_cnt_o=0, hazard_stall_o=0.
- Plain load: ADD control {0, 6'b000000, 9'b0_0000_0001}, pc_i=0x100, valid_i=1 -> identical values on outputs one cycle later, valid_o=1.
- Load-use: LW x5 (MEM_i[5:4]=1, WB_i=0, rd_i=5) followed by ADD with rs1_i=5 -> hazard_stall_o=1 for exactly 1 cycle. Next cycle outputs BUBBLE with valid_o=0 and bubble_cnt_o=1. The ADD appears in the following cycle.
- No false hazards: LW to x0, or LW x5 followed by an instruction using x6/x7 -> hazard_stall_o=0 and no bubble.
- Flush priority: load-use condition present plus flush_i=1 and stall_i=1 in the same cycle -> hazard_stall_o=0, next outputs BUBBLE, valid_o=0, counter unchanged.
- Stall hold and saturation: stall_i=1 for 3 cycles -> outputs constant. With CNT_W=2, force 5 load-use bubbles -> bubble_cnt_o sticks at 3.
